// File: rtl/bcd_mult11_gen_pkg.sv
// ---------------------------------------------------------------------------
// bcd_mult11_gen_pkg
//   Shared definitions for the BCD multiple-of-11 generator:
//   - state encoding of the generator FSM (IDLE/ALIGN/EMIT/DONE)
//   - BCD digit width and largest legal digit value
//   - digit saturation helper used when seed checking is disabled
//   No ports (package).
// ---------------------------------------------------------------------------
package bcd_mult11_gen_pkg;

  // Width of one BCD digit. It is fixed at 4 and is only exposed so that
  // ports can be sized from a single name.
  localparam int DIGIT_WIDTH = 4;

  // Largest value a BCD digit may hold.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Generator states. The encoding is visible on the state_dbg port, so
  // keep these values stable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Clamp a 4-bit nibble to the legal BCD range (A..F become 9).
  function automatic logic [3:0] bcd_sat(input logic [3:0] x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/bcd_mult11_gen_digit_inc.sv
// ---------------------------------------------------------------------------
// bcd_mult11_gen_digit_inc
//   One-digit BCD incrementer: sum = digit + inc + cin, folded back into the
//   0..9 range with a carry out. Chained four times by the generator to add
//   0001 (align) or 0011 (emit) to a 4-digit BCD value.
//
//   Ports
//     digit  in  4  input BCD digit (0..9)
//     cin    in  1  carry from the next lower digit
//     inc    in  1  this digit's own addend (0 or 1)
//     sum    out 4  resulting BCD digit
//     cout   out 1  carry into the next higher digit
// ---------------------------------------------------------------------------
module bcd_mult11_gen_digit_inc
  import bcd_mult11_gen_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       cin,
  input  logic       inc,
  output logic [3:0] sum,
  output logic       cout
);

  // digit <= 9 and inc + cin <= 2, so raw never exceeds 11 and a single
  // "subtract ten" correction is always enough.
  logic [4:0] raw;

  assign raw = {1'b0, digit} + {4'b0000, inc} + {4'b0000, cin};

  always_comb begin
    sum  = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      // 10 -> 0, 11 -> 1; the 4-bit subtraction wraps exactly as needed.
      sum  = raw[3:0] - 4'd10;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_mult11_gen.sv
// ---------------------------------------------------------------------------
// bcd_mult11_gen
//   Sequential generator of 4-digit BCD multiples of 11. On start the seed is
//   loaded and stepped by +1 until it is a multiple of 11 (ALIGN), then
//   successive multiples (+11 each) are streamed out (EMIT).
//
//   Parameters
//     WRAP     0: stop after 9999 is accepted; 1: continue from 0000
//     DIGIT_W  BCD digit width, fixed at 4 (port sizing only)
//
//   Configuration macro
//     BCD_CHECK_EN  defined  : adds output err; a start with any seed digit
//                              above 9 is rejected (stays IDLE, err=1); err
//                              clears on the next accepted start.
//                   undefined: no err port; seed digits above 9 are
//                              saturated to 9 and start is always accepted.
//
//   Ports
//     clk        in   1  clock, rising edge
//     rst_n      in   1  asynchronous active-low reset
//     start      in   1  load seed and begin (only looked at in IDLE)
//     seed_a..d  in   4  seed digits, a = thousands .. d = ones
//     a,b,c,d    out  4  current value, a = thousands .. d = ones
//     out_valid  out  1  a..d hold a multiple of 11
//     out_ready  in   1  consumer accepts a..d
//     busy       out  1  state != IDLE
//     done       out  1  one-cycle pulse after 9999 has been accepted
//     err        out  1  (BCD_CHECK_EN only) last start had a bad seed
//     state_dbg  out  2  current FSM state (state_t encoding)
//
//   Handshake: a value transfers on a rising edge where out_valid and
//   out_ready are both high. While out_valid is high a..d do not change, and
//   out_valid only falls after a transfer (or on reset). out_ready has no
//   effect while out_valid is low.
// ---------------------------------------------------------------------------
module bcd_mult11_gen
  import bcd_mult11_gen_pkg::*;
#(
  parameter int WRAP    = 0,
  parameter int DIGIT_W = DIGIT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIGIT_W-1:0] seed_a,
  input  logic [DIGIT_W-1:0] seed_b,
  input  logic [DIGIT_W-1:0] seed_c,
  input  logic [DIGIT_W-1:0] seed_d,
  output logic [DIGIT_W-1:0] a,
  output logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] c,
  output logic [DIGIT_W-1:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
`ifdef BCD_CHECK_EN
  output logic               err,
`endif
  output logic [1:0]         state_dbg
);

  state_t state;

  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Digit chains. Index 0 is the ones digit, index 3 the thousands digit.
  // -------------------------------------------------------------------------
  logic [3:0] cur_dig [4];
  logic [3:0] al_dig  [4];   // current value + 0001
  logic [3:0] em_dig  [4];   // current value + 0011
  logic       al_c    [5];
  logic       em_c    [5];

  assign cur_dig[0] = d;
  assign cur_dig[1] = c;
  assign cur_dig[2] = b;
  assign cur_dig[3] = a;

  assign al_c[0] = 1'b0;
  assign em_c[0] = 1'b0;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_digit
      // +1: only the ones digit adds, the rest only ripple the carry.
      bcd_mult11_gen_digit_inc u_align_inc (
        .digit (cur_dig[g]),
        .cin   (al_c[g]),
        .inc   ((g == 0) ? 1'b1 : 1'b0),
        .sum   (al_dig[g]),
        .cout  (al_c[g+1])
      );

      // +11: ones and tens digits add, hundreds/thousands only ripple.
      bcd_mult11_gen_digit_inc u_emit_inc (
        .digit (cur_dig[g]),
        .cin   (em_c[g]),
        .inc   ((g < 2) ? 1'b1 : 1'b0),
        .sum   (em_dig[g]),
        .cout  (em_c[g+1])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Divisibility by 11: alternating digit sum d - c + b - a lies in -18..18,
  // so the value is a multiple of 11 exactly when that sum is -11, 0 or 11.
  // -------------------------------------------------------------------------
  logic signed [5:0] alt_sum;
  logic              is_mult11;

  always_comb begin
    alt_sum = $signed({2'b00, d}) - $signed({2'b00, c})
            + $signed({2'b00, b}) - $signed({2'b00, a});
    is_mult11 = (alt_sum == 6'sd0) || (alt_sum == 6'sd11) ||
                (alt_sum == -6'sd11);
  end

  // In EMIT a..d always hold a multiple of 11. The only such value whose
  // +11 carries out of the thousands digit is 9999 (9988 + 11 = 9999 is the
  // last sum that fits), so the emit chain's final carry marks the top.
  logic at_top;

  assign at_top = em_c[4];

  // The align chain never carries out: 9999 is itself a multiple of 11 and
  // ends alignment first. The carry is still used as a guard so a corrupted
  // value can never wrap to 0000 while aligning.
  logic align_step_ok;

  assign align_step_ok = ~al_c[4];

`ifdef BCD_CHECK_EN
  logic seed_bad;

  assign seed_bad = (seed_a > BCD_MAX) || (seed_b > BCD_MAX) ||
                    (seed_c > BCD_MAX) || (seed_d > BCD_MAX);
`endif

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BCD_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef BCD_CHECK_EN
            if (seed_bad) begin
              err <= 1'b1;
            end else begin
              a     <= seed_a;
              b     <= seed_b;
              c     <= seed_c;
              d     <= seed_d;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= ST_ALIGN;
            end
`else
            a     <= bcd_sat(seed_a);
            b     <= bcd_sat(seed_b);
            c     <= bcd_sat(seed_c);
            d     <= bcd_sat(seed_d);
            busy  <= 1'b1;
            state <= ST_ALIGN;
`endif
          end
        end

        ST_ALIGN: begin
          if (is_mult11) begin
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end else if (align_step_ok) begin
            d <= al_dig[0];
            c <= al_dig[1];
            b <= al_dig[2];
            a <= al_dig[3];
          end
        end

        ST_EMIT: begin
          // out_valid is always high in this state, so out_ready alone
          // marks a transfer.
          if (out_ready) begin
            if (at_top) begin
              done <= 1'b1;
              if (WRAP != 0) begin
                a <= '0;
                b <= '0;
                c <= '0;
                d <= '0;
              end else begin
                out_valid <= 1'b0;
                state     <= ST_DONE;
              end
            end else begin
              d <= em_dig[0];
              c <= em_dig[1];
              b <= em_dig[2];
              a <= em_dig[3];
            end
          end
        end

        ST_DONE: begin
          // done was raised on the way in and is cleared by the default
          // above; a..d keep 9999.
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_mult11_gen.sv
// ---------------------------------------------------------------------------
// tb_bcd_mult11_gen
//   Bench for bcd_mult11_gen. Two instances share clock and reset:
//   index 0 is built with WRAP=0, index 1 with WRAP=1.
// ---------------------------------------------------------------------------
module tb_bcd_mult11_gen;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       start     [2];
  logic       out_ready [2];
  logic       out_valid [2];
  logic       busy      [2];
  logic       done      [2];
  logic [3:0] seed_a    [2];
  logic [3:0] seed_b    [2];
  logic [3:0] seed_c    [2];
  logic [3:0] seed_d    [2];
  logic [3:0] a         [2];
  logic [3:0] b         [2];
  logic [3:0] c         [2];
  logic [3:0] d         [2];
  logic [1:0] state_dbg [2];
`ifdef BCD_CHECK_EN
  logic       err       [2];
`endif

  bcd_mult11_gen #(.WRAP(0), .DIGIT_W(4)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start[0]),
    .seed_a    (seed_a[0]),
    .seed_b    (seed_b[0]),
    .seed_c    (seed_c[0]),
    .seed_d    (seed_d[0]),
    .a         (a[0]),
    .b         (b[0]),
    .c         (c[0]),
    .d         (d[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .busy      (busy[0]),
    .done      (done[0]),
`ifdef BCD_CHECK_EN
    .err       (err[0]),
`endif
    .state_dbg (state_dbg[0])
  );

  bcd_mult11_gen #(.WRAP(1), .DIGIT_W(4)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start[1]),
    .seed_a    (seed_a[1]),
    .seed_b    (seed_b[1]),
    .seed_c    (seed_c[1]),
    .seed_d    (seed_d[1]),
    .a         (a[1]),
    .b         (b[1]),
    .c         (c[1]),
    .d         (d[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .busy      (busy[1]),
    .done      (done[1]),
`ifdef BCD_CHECK_EN
    .err       (err[1]),
`endif
    .state_dbg (state_dbg[1])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int sat_digit(input logic [3:0] x);
    return (x > 4'd9) ? 9 : int'(x);
  endfunction

  function automatic int next_val(input int v);
    return (v == 9999) ? 0 : v + 11;
  endfunction

  function automatic logic [W-1:0] cur_val(input int sel);
    return {a[sel], b[sel], c[sel], d[sel]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           mon_sel  = 0;
  int           hs_cnt   = 0;
  int           done_cnt = 0;
  int           done_at  = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done[mon_sel]) begin
        done_cnt++;
        done_at = hs_cnt;
      end
      if (out_valid[mon_sel] && out_ready[mon_sel]) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("sb_value", 32'(cur_val(mon_sel)), 32'(exp_q.pop_front()));
        end
        hs_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic chk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    if (chk) begin
      for (int s = 0; s < 2; s++) begin
        check_eq("rst_value", 32'(cur_val(s)), 32'd0);
        check_eq("rst_valid", 32'(out_valid[s]), 32'd0);
        check_eq("rst_busy",  32'(busy[s]), 32'd0);
        check_eq("rst_done",  32'(done[s]), 32'd0);
        check_eq("rst_state", 32'(state_dbg[s]), 32'd0);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Start a run, check alignment latency, then accept n values with
  // out_ready held high. Expected values are queued before the start.
  task automatic run(input int sel, input logic [3:0] sa, input logic [3:0] sb,
                     input logic [3:0] sc, input logic [3:0] sd, input int n,
                     input logic chk_tput);
    int v;
    int k;
    int cyc;
    v = sat_digit(sa) * 1000 + sat_digit(sb) * 100 + sat_digit(sc) * 10 +
        sat_digit(sd);
    k = 0;
    while (v % 11 != 0) begin
      v++;
      k++;
    end
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(to_bcd(v));
      v = next_val(v);
    end
    mon_sel   = sel;
    hs_cnt    = 0;
    done_cnt  = 0;
    done_at   = -1;
    out_ready[sel] = (n > 0);
    seed_a[sel] = sa;
    seed_b[sel] = sb;
    seed_c[sel] = sc;
    seed_d[sel] = sd;
    start[sel]  = 1'b1;
    @(posedge clk);
    #1;
    start[sel] = 1'b0;
    cyc = 1;
    while (!out_valid[sel] && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(2 + k));
    cyc = 0;
    while (hs_cnt < n && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready[sel] = 1'b0;
    if (chk_tput) check_eq("throughput", 32'(cyc), 32'(n));
    check_eq("q_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int  exp_cur;
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0;
      out_ready[s] = 1'b0;
      seed_a[s] = 4'd0;
      seed_b[s] = 4'd0;
      seed_c[s] = 4'd0;
      seed_d[s] = 4'd0;
    end
    #3;
    for (int s = 0; s < 2; s++) begin
      check_eq("init_value", 32'(cur_val(s)), 32'd0);
      check_eq("init_valid", 32'(out_valid[s]), 32'd0);
      check_eq("init_busy",  32'(busy[s]), 32'd0);
      check_eq("init_done",  32'(done[s]), 32'd0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: seed 0000 -> 0000, 0011, 0022 back to back
    run(0, 4'd0, 4'd0, 4'd0, 4'd0, 3, 1'b1);
    do_reset(1'b0);

    // 2: seed 1234 -> nine +1 steps to 1243, then 1254
    run(0, 4'd1, 4'd2, 4'd3, 4'd4, 2, 1'b1);
    do_reset(1'b0);

    // 3: seed 9990 with WRAP=0 -> single 9999, done, back to IDLE
    run(0, 4'd9, 4'd9, 4'd9, 4'd0, 1, 1'b0);
    check_eq("t3_done_hi",  32'(done[0]), 32'd1);
    check_eq("t3_busy_hi",  32'(busy[0]), 32'd1);
    check_eq("t3_valid_lo", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t3_done_lo",  32'(done[0]), 32'd0);
    check_eq("t3_busy_lo",  32'(busy[0]), 32'd0);
    check_eq("t3_state",    32'(state_dbg[0]), 32'd0);
    check_eq("t3_hold",     32'(cur_val(0)), 32'h9999);
    check_eq("t3_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t3_done_at",  32'(done_at), 32'd1);
    run(0, 4'd0, 4'd0, 4'd0, 4'd0, 1, 1'b0);
    do_reset(1'b0);

    // 5: stalls during EMIT; a start pulse while stalled must be ignored
    run(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    exp_cur = 0;
    hs_cnt  = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) exp_q.push_back(to_bcd(exp_cur));
      out_ready[0] = pat[i];
      if (!pat[i]) begin
        seed_a[0] = 4'd5;
        seed_b[0] = 4'd5;
        seed_c[0] = 4'd5;
        seed_d[0] = 4'd5;
        start[0]  = 1'b1;
      end
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      if (pat[i]) exp_cur = next_val(exp_cur);
      check_eq(pat[i] ? "emit_step" : "stall_hold", 32'(cur_val(0)),
               32'(to_bcd(exp_cur)));
      check_eq("stall_valid", 32'(out_valid[0]), 32'd1);
    end
    out_ready[0] = 1'b0;
    @(negedge clk);
    check_eq("t5_hs_cnt", 32'(hs_cnt), 32'd4);
    check_eq("t5_q_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // 4: WRAP=1 from 9988 -> 9988, 9999, 0000; done with the 9999 transfer
    run(1, 4'd9, 4'd9, 4'd8, 4'd8, 3, 1'b1);
    check_eq("t4_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t4_done_at",  32'(done_at), 32'd2);
    check_eq("t4_valid",    32'(out_valid[1]), 32'd1);
    check_eq("t4_busy",     32'(busy[1]), 32'd1);
    check_eq("t4_next",     32'(cur_val(1)), 32'(to_bcd(11)));

    // 6: reset while both instances sit in EMIT, then a non-BCD seed
    do_reset(1'b1);
`ifdef BCD_CHECK_EN
    seed_a[0] = 4'd1;
    seed_b[0] = 4'd2;
    seed_c[0] = 4'hA;
    seed_d[0] = 4'd4;
    start[0]  = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    check_eq("t6_err_set", 32'(err[0]), 32'd1);
    check_eq("t6_busy",    32'(busy[0]), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t6_state",   32'(state_dbg[0]), 32'd0);
    run(0, 4'd1, 4'd2, 4'd9, 4'd4, 2, 1'b1);
    check_eq("t6_err_clr", 32'(err[0]), 32'd0);
`else
    run(0, 4'd1, 4'd2, 4'hA, 4'd4, 2, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
